// File: rtl/flit_tx_credit.sv
// Transmit side of a router-to-router link: credit-gated flit forwarding with
// per-VC credit counters and wormhole framing checks.

package flit_tx_credit_pkg;
    localparam int unsigned PAYLOAD_W = 32;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t            flit_label;
        logic [PAYLOAD_W-1:0]   payload;
    } flit_t;
endpackage

module flit_tx_credit
    import flit_tx_credit_pkg::*;
#(
    parameter  int unsigned VC_NUM      = 2,
    parameter  int unsigned BUFFER_SIZE = 4,
    localparam int unsigned VW          = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    localparam int unsigned CW          = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  flit_t                data_i,
    input  logic [VW-1:0]        vc_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output flit_t                data_o,
    output logic [VW-1:0]        vc_o,
    output logic                 valid_o,
    input  logic [VC_NUM-1:0]    credit_i,
    output logic [VC_NUM*CW-1:0] credit_cnt_o,
    output logic                 idle_o,
    output logic                 err_o
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BUFFER_SIZE);

    logic [CW-1:0] cnt_q   [VC_NUM];
    logic [CW-1:0] cnt_d   [VC_NUM];
    logic [0:0]    state_q [VC_NUM];
    logic [0:0]    state_d [VC_NUM];

    logic          valid_q, valid_d;
    flit_t         data_q,  data_d;
    logic [VW-1:0] vc_q,    vc_d;
    logic          err_q,   err_d;
    logic          idle_q,  idle_d;

    logic              vc_ok_c;
    logic              xfer_c;
    logic [VC_NUM-1:0] send_c;

    // Accept whenever the addressed VC has at least one downstream slot free
    always_comb begin
        vc_ok_c = 32'(vc_i) < VC_NUM;
        ready_o = 1'b0;
        if (vc_ok_c) begin
            ready_o = (cnt_q[vc_i] != '0);
        end
        xfer_c = valid_i && ready_o;
        send_c = '0;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            send_c[v] = xfer_c && (vc_i == VW'(v));
        end
    end

    // Next-state: link register, credit counters, framing FSMs, sticky error, idle
    always_comb begin
        valid_d = xfer_c;
        data_d  = data_q;
        vc_d    = vc_q;
        err_d   = err_q;
        idle_d  = 1'b1;

        if (xfer_c) begin
            data_d = data_i;
            vc_d   = vc_i;
        end

        for (int unsigned v = 0; v < VC_NUM; v++) begin
            cnt_d[v]   = cnt_q[v];
            state_d[v] = state_q[v];

            if (send_c[v] && !credit_i[v]) begin
                cnt_d[v] = cnt_q[v] - CW'(1);
            end else if (credit_i[v] && !send_c[v]) begin
                // A credit beyond the buffer depth means downstream lost track
                if (cnt_q[v] == CNT_MAX) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[v] = cnt_q[v] + CW'(1);
                end
            end

            if (send_c[v]) begin
                case (data_i.flit_label)
                    HEAD: begin
                        if (state_q[v] == ST_ACTIVE) err_d = 1'b1;
                        state_d[v] = ST_ACTIVE;
                    end
                    BODY: begin
                        if (state_q[v] == ST_IDLE) err_d = 1'b1;
                    end
                    TAIL: begin
                        if (state_q[v] == ST_IDLE) err_d = 1'b1;
                        state_d[v] = ST_IDLE;
                    end
                    HEADTAIL: begin
                        if (state_q[v] == ST_ACTIVE) err_d = 1'b1;
                        state_d[v] = ST_IDLE;
                    end
                    default: begin
                        state_d[v] = state_q[v];
                    end
                endcase
            end

            if ((cnt_d[v] != CNT_MAX) || (state_d[v] != ST_IDLE)) begin
                idle_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            vc_q    <= '0;
            err_q   <= 1'b0;
            idle_q  <= 1'b1;
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                cnt_q[v]   <= CNT_MAX;
                state_q[v] <= ST_IDLE;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            vc_q    <= vc_d;
            err_q   <= err_d;
            idle_q  <= idle_d;
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                cnt_q[v]   <= cnt_d[v];
                state_q[v] <= state_d[v];
            end
        end
    end

    always_comb begin
        credit_cnt_o = '0;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            credit_cnt_o[v*CW +: CW] = cnt_q[v];
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign vc_o    = vc_q;
    assign err_o   = err_q;
    assign idle_o  = idle_q;

endmodule

// File: tb/tb_flit_tx_credit.sv
// Directed plus randomized bench for flit_tx_credit against a credit/packet reference model.

module tb_flit_tx_credit;
    import flit_tx_credit_pkg::*;

    localparam int VC_NUM = 2;
    localparam int BS     = 4;
    localparam int CW     = 3;

    logic               clk;
    logic               rst;
    flit_t              data_i;
    logic [0:0]         vc_i;
    logic               valid_i;
    logic               ready_o;
    flit_t              data_o;
    logic [0:0]         vc_o;
    logic               valid_o;
    logic [1:0]         credit_i;
    logic [VC_NUM*CW-1:0] credit_cnt_o;
    logic               idle_o;
    logic               err_o;

    flit_tx_credit #(.VC_NUM(VC_NUM), .BUFFER_SIZE(BS)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .vc_i         (vc_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .vc_o         (vc_o),
        .valid_o      (valid_o),
        .credit_i     (credit_i),
        .credit_cnt_o (credit_cnt_o),
        .idle_o       (idle_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: free downstream slots and "inside a packet" per VC
    int    mcnt  [VC_NUM];
    bit    inpkt [VC_NUM];
    bit    merr;
    bit    exp_valid;
    flit_t exp_data;
    bit    exp_vc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VC_NUM*CW-1:0] packed_counts();
        logic [VC_NUM*CW-1:0] p;
        p = '0;
        for (int i = 0; i < VC_NUM; i++) p[i*CW +: CW] = CW'(mcnt[i]);
        return p;
    endfunction

    function automatic bit model_idle();
        bit r;
        r = 1'b1;
        for (int i = 0; i < VC_NUM; i++) if (mcnt[i] != BS || inpkt[i]) r = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < VC_NUM; i++) begin
            mcnt[i]  = BS;
            inpkt[i] = 1'b0;
        end
        merr      = 1'b0;
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_vc    = 1'b0;
    endtask

    task automatic check_outputs(input string where);
        chk({where, ":valid_o"}, 64'(valid_o), 64'(exp_valid));
        chk({where, ":data_o"},  64'(data_o),  64'(exp_data));
        chk({where, ":vc_o"},    64'(vc_o),    64'(exp_vc));
        chk({where, ":cnt"},     64'(credit_cnt_o), 64'(packed_counts()));
        chk({where, ":err_o"},   64'(err_o),   64'(merr));
        chk({where, ":idle_o"},  64'(idle_o),  64'(model_idle()));
    endtask

    task automatic do_reset();
        valid_i  = 1'b0;
        data_i   = '0;
        vc_i     = 1'b0;
        credit_i = 2'b00;
        rst      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("reset");
    endtask

    // One clock: apply inputs, check ready, update model, check registered outputs
    task automatic cycle(input bit v, input flit_label_t lab, input int vc, input bit [1:0] cr, input string tag);
        flit_t f;
        bit    rdy;
        bit    xfer;
        f.flit_label = lab;
        f.payload    = $urandom;
        valid_i  = v;
        data_i   = f;
        vc_i     = 1'(vc);
        credit_i = cr;
        #1;
        rdy = (vc < VC_NUM) && (mcnt[vc] > 0);
        chk({tag, ":ready_o"}, 64'(ready_o), 64'(rdy));
        xfer = v && rdy;
        exp_valid = xfer;
        if (xfer) begin
            exp_data = f;
            exp_vc   = 1'(vc);
            case (lab)
                HEAD:     begin if (inpkt[vc])  merr = 1'b1; inpkt[vc] = 1'b1; end
                BODY:     begin if (!inpkt[vc]) merr = 1'b1; end
                TAIL:     begin if (!inpkt[vc]) merr = 1'b1; inpkt[vc] = 1'b0; end
                default:  begin if (inpkt[vc])  merr = 1'b1; inpkt[vc] = 1'b0; end
            endcase
        end
        for (int i = 0; i < VC_NUM; i++) begin
            mcnt[i] = mcnt[i] - ((xfer && vc == i) ? 1 : 0) + (cr[i] ? 1 : 0);
            if (mcnt[i] > BS) begin
                mcnt[i] = BS;
                merr    = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        #2;

        // Reset state and VC0 readiness
        do_reset();
        vc_i = 1'b0;
        #1;
        chk("reset:ready_o", 64'(ready_o), 64'(1));

        // Exhaust VC0 credits; the fifth flit is refused
        cycle(1, HEAD, 0, 2'b00, "exh_h");
        cycle(1, BODY, 0, 2'b00, "exh_b1");
        cycle(1, BODY, 0, 2'b00, "exh_b2");
        cycle(1, TAIL, 0, 2'b00, "exh_t");
        cycle(1, HEAD, 0, 2'b00, "exh_blocked");
        cycle(0, HEAD, 1, 2'b00, "vc1_ready");

        // Credit return reopens VC0 on the following cycle only
        cycle(1, HEAD, 0, 2'b01, "cr_nobypass");
        cycle(1, HEAD, 0, 2'b00, "cr_send");

        // Simultaneous send and credit, then overflow credit
        cycle(1, HEAD, 1, 2'b00, "sim_h");
        cycle(1, BODY, 1, 2'b00, "sim_b");
        cycle(1, BODY, 1, 2'b10, "sim_same");
        for (int k = 0; k < BS; k++) begin
            bit [1:0] cr;
            for (int i = 0; i < VC_NUM; i++) cr[i] = (mcnt[i] < BS);
            cycle(0, HEAD, 0, cr, "refill");
        end
        cycle(1, TAIL, 1, 2'b10, "full_send_cr");
        cycle(0, HEAD, 0, 2'b11, "overflow");

        // Interleaved legal framing, then a stray BODY
        do_reset();
        cycle(1, HEAD, 0, 2'b00, "il_h0");
        cycle(1, HEAD, 1, 2'b00, "il_h1");
        cycle(1, TAIL, 0, 2'b01, "il_t0");
        cycle(1, TAIL, 1, 2'b10, "il_t1");
        cycle(0, HEAD, 0, 2'b11, "il_idle");
        cycle(1, BODY, 1, 2'b00, "stray_body");

        // Randomized traffic with mostly legal framing and credit returns
        do_reset();
        for (int n = 0; n < 400; n++) begin
            int          vc;
            flit_label_t lab;
            bit [1:0]    cr;
            vc = int'($urandom_range(0, VC_NUM - 1));
            if ($urandom_range(0, 7) == 0) lab = flit_label_t'($urandom_range(0, 3));
            else if (inpkt[vc]) lab = ($urandom_range(0, 2) == 0) ? TAIL : BODY;
            else lab = ($urandom_range(0, 3) == 0) ? HEADTAIL : HEAD;
            for (int i = 0; i < VC_NUM; i++) begin
                cr[i] = ((mcnt[i] < BS) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 63) == 0);
            end
            cycle(bit'($urandom_range(0, 3) != 0), lab, vc, cr, "rand");
        end

        // Asynchronous reset mid-packet with one VC0 credit left
        do_reset();
        cycle(1, HEAD, 0, 2'b00, "ar_h");
        cycle(1, BODY, 0, 2'b00, "ar_b1");
        cycle(1, BODY, 0, 2'b00, "ar_b2");
        valid_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async:valid_o", 64'(valid_o), 64'(0));
        chk("async:cnt", 64'(credit_cnt_o), 64'({3'd4, 3'd4}));
        chk("async:err_o", 64'(err_o), 64'(0));
        chk("async:idle_o", 64'(idle_o), 64'(1));
        @(negedge clk);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
